alu_ctrl: RTL and testbench
===========================

ALU_CTRL -- requirements
Module: alu_ctrl

Interface
REQ-001 Parameter: EXEC_CYCLES, 1, ALU settle cycles per operation (legal 1..15).
REQ-002 clk  in  1  rising-edge clock.
REQ-003 rst_n  in  1  synchronous active-low reset.
REQ-004 req0_valid, req1_valid  in  1 each  requester N has an operation pending.
REQ-005 req0_opcode, req1_opcode  in  8 each  ALU opcode (0..22 per team ALU encoding).
REQ-006 req0_a, req0_b, req1_a, req1_b  in  16 each  operands.
REQ-007 req0_ready, req1_ready  out  1 each  request accepted this cycle when valid also high.
REQ-008 alu_a, alu_b  out  16 each; alu_opcode  out  8  drive to shared ALU.
REQ-009 alu_c  in  16; alu_carry, alu_flag, alu_low, alu_negative, alu_zero  in  1 each  ALU results.
REQ-010 rsp_valid  out  1; rsp_ready  in  1  response handshake.
REQ-011 rsp_id  out  1  requester index; rsp_c  out  16  result; rsp_flags  out  5  {Carry,Flag,Low,Negative,Zero}; rsp_err  out  1  illegal opcode.

Function
REQ-012 FSM states IDLE, EXEC, RESP shall be implemented; reset state IDLE.
REQ-013 In IDLE, reqN_ready shall be high only for the granted requester; both low in EXEC and RESP.
REQ-014 Arbitration: single valid requester wins; both valid -> requester not granted last wins (round-robin); last-grant pointer reset value 1 so req0 wins first contest.
REQ-015 Handshake cycle k (valid & ready): opcode, operands, id captured; next state EXEC, or RESP directly for NOP (22) or illegal opcodes.
REQ-016 Illegal opcode = 7 (ADDCI) or >22: no ALU dispatch; response rsp_err=1, rsp_c=0, rsp_flags=0, rsp_valid in cycle k+1.
REQ-017 NOP: rsp_err=0, rsp_c=0, rsp_flags=0, rsp_valid in cycle k+1.
REQ-018 EXEC: alu_a/alu_b/alu_opcode held from capture registers for exactly EXEC_CYCLES cycles; ALU outputs sampled at end of cycle k+EXEC_CYCLES; rsp_valid first high in cycle k+EXEC_CYCLES+1.
REQ-019 Outside EXEC, alu_opcode shall be 22 (NOP) and alu_a/alu_b 0.
REQ-020 Flag masking (unlisted bits forced 0): ops 0,2,4,8,9 -> Flag,Zero; ops 1,3,5,6 -> Carry,Zero; op 10 -> Low,Negative,Zero; op 11 -> Low,Zero; ops 12-21 -> none.
REQ-021 rsp_c shall be forced 0 for ops 10,11; otherwise alu_c as sampled.
REQ-022 RESP: rsp_valid and all rsp_* held stable until rsp_ready high; that cycle -> IDLE; new request acceptable the following cycle (no same-cycle bypass).
REQ-023 rsp_ready while rsp_valid low shall be ignored; requests arriving in EXEC/RESP stall (valid held by requester, no drop).

Reset
REQ-024 rst_n low at a rising edge: state IDLE, rsp_valid=0, rsp_id=0, rsp_c=0, rsp_flags=0, rsp_err=0, counter=0, last-grant=1, capture registers 0.
REQ-025 Reset mid-EXEC or mid-RESP shall abandon the operation; no response emitted afterwards.
REQ-026 reqN_ready shall be 0 in every cycle rst_n is low.

Configuration
REQ-027 Macro ALU_CTRL_PSR_EN defined: outputs psr0, psr1 (5 bits each, same bit order as rsp_flags) added; psrN loaded with masked flags when an op 0-11 from requester N completes (RESP accepted); ops 12-22 and illegal ops leave psrN unchanged; reset value 0.
REQ-028 ALU_CTRL_PSR_EN undefined: psr0/psr1 ports and registers absent; all other behaviour identical.

Verification
REQ-029 EXEC_CYCLES=1, req0 ADD(0) a=0x7FFF b=0x0001, rsp_ready=1 -> rsp_valid cycle k+2, rsp_c=0x8000, rsp_flags=5'b01000, rsp_id=0.
REQ-030 Both valid continuously, ADDU(1) a=0xFFFF b=0x0001 -> grants alternate req0,req1,req0; each rsp_c=0x0000, rsp_flags=5'b10001.
REQ-031 req1 CMP(10) a=0x0001 b=0xFFFF -> rsp_c=0, rsp_flags=5'b00100 (Low=1, Negative=0, Zero=0); with ALU_CTRL_PSR_EN, psr1=5'b00100, psr0 unchanged.
REQ-032 req0 opcode 7 then opcode 30 -> each rsp_err=1, rsp_c=0, rsp_flags=0, rsp_valid cycle k+1, alu_opcode stays 22.
REQ-033 EXEC_CYCLES=3, rsp_ready held 0 for 5 cycles after rsp_valid -> rsp_* stable, req0_ready/req1_ready low throughout; accepted on rsp_ready=1, IDLE next cycle.
REQ-034 rst_n low during EXEC of SUB(8) a=5 b=3 -> rsp_valid never asserts for it; next req0 grant after reset release behaves per REQ-029.

Source files
------------

// File: rtl/alu_ctrl.sv
// alu_ctrl: round-robin front end sharing one multi-cycle ALU between two requesters.
// Define ALU_CTRL_PSR_EN to add per-requester status registers psr0/psr1.
//
// state | meaning
// IDLE  | no operation in flight; ready offered to the arbitration winner
// EXEC  | captured operands driven to the ALU for EXEC_CYCLES cycles
// RESP  | response held on rsp_* until rsp_ready

module alu_ctrl #(
    parameter int EXEC_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req0_valid,
    input  logic        req1_valid,
    input  logic [7:0]  req0_opcode,
    input  logic [7:0]  req1_opcode,
    input  logic [15:0] req0_a,
    input  logic [15:0] req0_b,
    input  logic [15:0] req1_a,
    input  logic [15:0] req1_b,
    output logic        req0_ready,
    output logic        req1_ready,
    output logic [15:0] alu_a,
    output logic [15:0] alu_b,
    output logic [7:0]  alu_opcode,
    input  logic [15:0] alu_c,
    input  logic        alu_carry,
    input  logic        alu_flag,
    input  logic        alu_low,
    input  logic        alu_negative,
    input  logic        alu_zero,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic        rsp_id,
    output logic [15:0] rsp_c,
    output logic [4:0]  rsp_flags,
`ifdef ALU_CTRL_PSR_EN
    output logic [4:0]  psr0,
    output logic [4:0]  psr1,
`endif
    output logic        rsp_err
);

    localparam logic [7:0] OP_NOP   = 8'd22;
    localparam logic [3:0] CNT_LOAD = 4'(EXEC_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic        last_grant;
    logic        grant1;
    logic        accept;
    logic [7:0]  sel_op;
    logic [15:0] sel_a;
    logic [15:0] sel_b;
    logic [7:0]  cap_op;
    logic [15:0] cap_a;
    logic [15:0] cap_b;
    logic [3:0]  cnt;
    logic [4:0]  alu_flags;

    function automatic logic is_illegal(input logic [7:0] op);
        return (op == 8'd7) || (op > OP_NOP);
    endfunction

    // bit order {Carry, Flag, Low, Negative, Zero}
    function automatic logic [4:0] flag_mask(input logic [7:0] op);
        case (op)
            8'd0, 8'd2, 8'd4, 8'd8, 8'd9: flag_mask = 5'b01001;
            8'd1, 8'd3, 8'd5, 8'd6:       flag_mask = 5'b10001;
            8'd10:                        flag_mask = 5'b00111;
            8'd11:                        flag_mask = 5'b00101;
            default:                      flag_mask = 5'b00000;
        endcase
    endfunction

    assign alu_flags = {alu_carry, alu_flag, alu_low, alu_negative, alu_zero};

    // on contention the requester that was not granted last time wins
    always_comb begin
        grant1 = req1_valid & (~req0_valid | ~last_grant);
        sel_op = grant1 ? req1_opcode : req0_opcode;
        sel_a  = grant1 ? req1_a : req0_a;
        sel_b  = grant1 ? req1_b : req0_b;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt = (is_illegal(sel_op) || sel_op == OP_NOP) ? RESP : EXEC;
                end
            end
            EXEC: begin
                if (cnt == 4'd0) begin
                    state_nxt = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        alu_opcode = OP_NOP;
        alu_a      = 16'd0;
        alu_b      = 16'd0;
        rsp_valid  = (state == RESP);
        if (state == IDLE && rst_n) begin
            req0_ready = req0_valid & ~grant1;
            req1_ready = grant1;
        end
        if (state == EXEC) begin
            alu_opcode = cap_op;
            alu_a      = cap_a;
            alu_b      = cap_b;
        end
        accept = req0_ready | req1_ready;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            last_grant <= 1'b1;
            cap_op     <= 8'd0;
            cap_a      <= 16'd0;
            cap_b      <= 16'd0;
            cnt        <= 4'd0;
            rsp_id     <= 1'b0;
            rsp_c      <= 16'd0;
            rsp_flags  <= 5'd0;
            rsp_err    <= 1'b0;
        end else begin
            if (accept) begin
                last_grant <= grant1;
                cap_op     <= sel_op;
                cap_a      <= sel_a;
                cap_b      <= sel_b;
                cnt        <= CNT_LOAD;
                rsp_id     <= grant1;
                rsp_c      <= 16'd0;
                rsp_flags  <= 5'd0;
                rsp_err    <= is_illegal(sel_op);
            end
            if (state == EXEC) begin
                if (cnt != 4'd0) begin
                    cnt <= cnt - 4'd1;
                end else begin
                    rsp_c     <= (cap_op == 8'd10 || cap_op == 8'd11) ? 16'd0 : alu_c;
                    rsp_flags <= alu_flags & flag_mask(cap_op);
                    rsp_err   <= 1'b0;
                end
            end
        end
    end

`ifdef ALU_CTRL_PSR_EN
    // status is committed only when the response is taken
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            psr0 <= 5'd0;
            psr1 <= 5'd0;
        end else if (state == RESP && rsp_ready && !rsp_err && cap_op <= 8'd11) begin
            if (rsp_id) begin
                psr1 <= rsp_flags;
            end else begin
                psr0 <= rsp_flags;
            end
        end
    end
`endif

endmodule

// File: tb/tb_alu_ctrl.sv
// tb_alu_ctrl: directed vector table, hand sequences for stall/reset/round-robin,
// and a randomized run against a transaction-level model. Honours ALU_CTRL_PSR_EN.

module tb_alu_ctrl;

    localparam int EC = 3;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req0_valid, req1_valid;
    logic [7:0]  req0_opcode, req1_opcode;
    logic [15:0] req0_a, req0_b, req1_a, req1_b;
    logic        req0_ready, req1_ready;
    logic [15:0] alu_a, alu_b, alu_c;
    logic [7:0]  alu_opcode;
    logic        alu_carry, alu_flag, alu_low, alu_negative, alu_zero;
    logic        rsp_valid, rsp_ready, rsp_id, rsp_err;
    logic [15:0] rsp_c;
    logic [4:0]  rsp_flags;
`ifdef ALU_CTRL_PSR_EN
    logic [4:0]  psr0, psr1;
`endif

    int checks = 0;
    int errors = 0;
    logic [4:0] psr_m [2];

    always #5 clk = ~clk;

    alu_ctrl #(.EXEC_CYCLES(EC)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req1_valid(req1_valid),
        .req0_opcode(req0_opcode), .req1_opcode(req1_opcode),
        .req0_a(req0_a), .req0_b(req0_b), .req1_a(req1_a), .req1_b(req1_b),
        .req0_ready(req0_ready), .req1_ready(req1_ready),
        .alu_a(alu_a), .alu_b(alu_b), .alu_opcode(alu_opcode),
        .alu_c(alu_c), .alu_carry(alu_carry), .alu_flag(alu_flag),
        .alu_low(alu_low), .alu_negative(alu_negative), .alu_zero(alu_zero),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_c(rsp_c), .rsp_flags(rsp_flags),
`ifdef ALU_CTRL_PSR_EN
        .psr0(psr0), .psr1(psr1),
`endif
        .rsp_err(rsp_err)
    );

    // ALU model: {c, Carry, Flag, Low, Negative, Zero}
    function automatic logic [20:0] alu_fn(input logic [7:0] op, input logic [15:0] a, input logic [15:0] b);
        logic [16:0] s;
        logic [15:0] c;
        logic        cy, ov;
        if (op <= 8'd7) begin
            s  = {1'b0, a} + {1'b0, b};
            c  = s[15:0];
            cy = s[16];
            ov = (a[15] == b[15]) && (c[15] != a[15]);
        end else if (op <= 8'd11) begin
            s  = {1'b0, a} - {1'b0, b};
            c  = s[15:0];
            cy = s[16];
            ov = (a[15] != b[15]) && (c[15] != a[15]);
        end else begin
            case (op[1:0])
                2'd0:    c = a & b;
                2'd1:    c = a | b;
                2'd2:    c = a ^ b;
                default: c = ~a;
            endcase
            cy = 1'b0;
            ov = 1'b0;
        end
        return {c, cy, ov, a < b, $signed(a) < $signed(b), c == 16'd0};
    endfunction

    // ALU outputs are garbage until inputs have been stable EC cycles
    logic [39:0] alu_prev = '0;
    int          alu_age  = 0;
    logic [20:0] alu_res;
    always @(negedge clk) begin
        alu_age  <= ({alu_opcode, alu_a, alu_b} == alu_prev) ? alu_age + 1 : 1;
        alu_prev <= {alu_opcode, alu_a, alu_b};
    end
    always_comb begin
        alu_res = alu_fn(alu_opcode, alu_a, alu_b);
        if (alu_age < EC) alu_res = {16'hDEAD, 5'b11111};
    end
    assign alu_c = alu_res[20:5];
    assign {alu_carry, alu_flag, alu_low, alu_negative, alu_zero} = alu_res[4:0];

    function automatic logic [4:0] mask_of(input logic [7:0] op);
        if (op inside {8'd0, 8'd2, 8'd4, 8'd8, 8'd9}) return 5'b01001;
        if (op inside {8'd1, 8'd3, 8'd5, 8'd6})       return 5'b10001;
        if (op == 8'd10)                              return 5'b00111;
        if (op == 8'd11)                              return 5'b00101;
        return 5'b00000;
    endfunction

    // expected {err, c, flags}
    function automatic logic [21:0] ref_rsp(input logic [7:0] op, input logic [15:0] a, input logic [15:0] b);
        logic [20:0] r;
        logic [15:0] c;
        if (op == 8'd7 || op > 8'd22) return {1'b1, 21'd0};
        if (op == 8'd22) return 22'd0;
        r = alu_fn(op, a, b);
        c = (op == 8'd10 || op == 8'd11) ? 16'd0 : r[20:5];
        return {1'b0, c, r[4:0] & mask_of(op)};
    endfunction

    function automatic int latency(input logic [7:0] op);
        return (op == 8'd7 || op >= 8'd22) ? 1 : EC + 1;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic psr_note(input int id, input logic [7:0] op, input logic [4:0] f);
        if (op <= 8'd11 && op != 8'd7) psr_m[id] = f;
    endtask

    task automatic psr_check(input string nm);
`ifdef ALU_CTRL_PSR_EN
        chk({nm, "_psr"}, {psr0, psr1}, {psr_m[0], psr_m[1]});
`else
        if (nm.len() == 0) $display("psr check skipped");
`endif
    endtask

    task automatic do_reset(input int n);
        rst_n = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            chk("rst_ready", {req0_ready, req1_ready}, 2'b00);
            tick();
        end
        rst_n = 1'b1;
        psr_m[0] = 5'd0;
        psr_m[1] = 5'd0;
    endtask

    task automatic do_op(input string nm, input int id, input logic [7:0] op, input logic [15:0] a,
                         input logic [15:0] b, input logic [21:0] exp, input bit contest);
        int n;
        int lat;
        rsp_ready = 1'b1;
        if (id == 0) begin
            req0_valid = 1'b1; req0_opcode = op; req0_a = a; req0_b = b;
            if (contest) begin req1_valid = 1'b1; req1_opcode = 8'd22; end
        end else begin
            req1_valid = 1'b1; req1_opcode = op; req1_a = a; req1_b = b;
            if (contest) begin req0_valid = 1'b1; req0_opcode = 8'd22; end
        end
        n = 0;
        @(negedge clk);
        while (!(id == 0 ? req0_ready : req1_ready) && n < 20) begin
            tick();
            @(negedge clk);
            n++;
        end
        chk({nm, "_wait"}, n, 0);
        chk({nm, "_other_ready"}, (id == 0) ? req1_ready : req0_ready, 1'b0);
        tick();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        lat = 1;
        @(negedge clk);
        while (!rsp_valid && lat < 40) begin
            if (latency(op) > 1) chk({nm, "_exec_drive"}, {alu_opcode, alu_a, alu_b}, {op, a, b});
            tick();
            @(negedge clk);
            lat++;
        end
        chk({nm, "_lat"}, lat, latency(op));
        chk({nm, "_id"}, rsp_id, id);
        chk({nm, "_rsp"}, {rsp_err, rsp_c, rsp_flags}, exp);
        chk({nm, "_alu_idle"}, {alu_opcode, alu_a, alu_b}, {8'd22, 32'd0});
        psr_note(id, op, exp[4:0]);
        tick();
        @(negedge clk);
        chk({nm, "_done"}, rsp_valid, 1'b0);
        psr_check(nm);
        tick();
    endtask

    typedef struct {
        string       nm;
        int          id;
        logic [7:0]  op;
        logic [15:0] a;
        logic [15:0] b;
        logic        err;
        logic [15:0] c;
        logic [4:0]  f;
    } vec_t;

    vec_t tbl[10];

    initial begin
        int n;
        int m_busy, m_last, m_cnt, m_id, g;
        logic [7:0]  m_op;
        logic [15:0] m_a, m_b;
        logic [21:0] m_exp;
        logic        pv [2];
        logic [7:0]  pop [2];
        logic [15:0] pa [2];
        logic [15:0] pb [2];

        tbl[0] = '{"add_ovf",  0, 8'd0,  16'h7FFF, 16'h0001, 1'b0, 16'h8000, 5'b01000};
        tbl[1] = '{"cmp",      1, 8'd10, 16'h0001, 16'hFFFF, 1'b0, 16'h0000, 5'b00100};
        tbl[2] = '{"ill7",     0, 8'd7,  16'h1234, 16'h5678, 1'b1, 16'h0000, 5'b00000};
        tbl[3] = '{"ill30",    0, 8'd30, 16'h1234, 16'h5678, 1'b1, 16'h0000, 5'b00000};
        tbl[4] = '{"nop",      1, 8'd22, 16'hFFFF, 16'hFFFF, 1'b0, 16'h0000, 5'b00000};
        tbl[5] = '{"sub",      0, 8'd8,  16'h0005, 16'h0003, 1'b0, 16'h0002, 5'b00000};
        tbl[6] = '{"addu_cy",  1, 8'd1,  16'hFFFF, 16'h0001, 1'b0, 16'h0000, 5'b10001};
        tbl[7] = '{"cmpu",     0, 8'd11, 16'h0002, 16'h0005, 1'b0, 16'h0000, 5'b00100};
        tbl[8] = '{"and",      1, 8'd12, 16'hF0F0, 16'h0FF0, 1'b0, 16'h00F0, 5'b00000};
        tbl[9] = '{"ill23",    0, 8'd23, 16'h0001, 16'h0001, 1'b1, 16'h0000, 5'b00000};

        req0_valid = 1'b1; req1_valid = 1'b1;
        req0_opcode = 8'd0; req1_opcode = 8'd0;
        req0_a = 16'd0; req0_b = 16'd0; req1_a = 16'd0; req1_b = 16'd0;
        rsp_ready = 1'b0;
        do_reset(3);
        req0_valid = 1'b0; req1_valid = 1'b0;
        @(negedge clk);
        chk("reset_rsp", {rsp_valid, rsp_id, rsp_err, rsp_c, rsp_flags}, 24'd0);
        chk("reset_alu", {alu_opcode, alu_a, alu_b}, {8'd22, 32'd0});
        psr_check("reset");
        tick();

        foreach (tbl[i]) do_op(tbl[i].nm, tbl[i].id, tbl[i].op, tbl[i].a, tbl[i].b,
                               {tbl[i].err, tbl[i].c, tbl[i].f}, 1'b0);

        // both requesters valid continuously: grants alternate starting with req0
        req0_valid = 1'b1; req1_valid = 1'b1;
        do_reset(2);
        req0_opcode = 8'd1; req0_a = 16'hFFFF; req0_b = 16'h0001;
        req1_opcode = 8'd1; req1_a = 16'hFFFF; req1_b = 16'h0001;
        rsp_ready = 1'b1;
        for (int t = 0; t < 3; t++) begin
            n = 0;
            @(negedge clk);
            while (!(req0_ready | req1_ready) && n < 20) begin tick(); @(negedge clk); n++; end
            chk("rr_grant", {req1_ready, req0_ready}, (t == 1) ? 2'b10 : 2'b01);
            tick();
            n = 1;
            @(negedge clk);
            while (!rsp_valid && n < 40) begin tick(); @(negedge clk); n++; end
            chk("rr_lat", n, EC + 1);
            chk("rr_rsp", {rsp_id, rsp_err, rsp_c, rsp_flags}, {t == 1, 1'b0, 16'h0000, 5'b10001});
            psr_note((t == 1) ? 1 : 0, 8'd1, 5'b10001);
            tick();
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        @(negedge clk);
        psr_check("rr");
        tick();

        // response stall with a competing request waiting
        rsp_ready = 1'b0;
        req0_valid = 1'b1; req0_opcode = 8'd8; req0_a = 16'd5; req0_b = 16'd3;
        @(negedge clk);
        chk("hold_grant", req0_ready, 1'b1);
        tick();
        req0_valid = 1'b0;
        req1_valid = 1'b1; req1_opcode = 8'd0; req1_a = 16'd1; req1_b = 16'd2;
        n = 1;
        @(negedge clk);
        while (!rsp_valid && n < 40) begin
            chk("hold_busy_ready", {req0_ready, req1_ready}, 2'b00);
            tick(); @(negedge clk); n++;
        end
        chk("hold_lat", n, EC + 1);
        for (int i = 0; i < 5; i++) begin
            chk("hold_rsp", {rsp_valid, rsp_id, rsp_err, rsp_c, rsp_flags}, {3'b100, 16'd2, 5'd0});
            chk("hold_ready", {req0_ready, req1_ready}, 2'b00);
            tick();
            if (i < 4) @(negedge clk);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        chk("hold_accept", {rsp_valid, req1_ready}, 2'b10);
        psr_note(0, 8'd8, 5'd0);
        tick();
        @(negedge clk);
        chk("hold_idle_next", {rsp_valid, req1_ready}, 2'b01);
        tick();
        req1_valid = 1'b0;
        n = 1;
        @(negedge clk);
        while (!rsp_valid && n < 40) begin tick(); @(negedge clk); n++; end
        chk("hold_r1_lat", n, EC + 1);
        chk("hold_r1_rsp", {rsp_id, rsp_err, rsp_c, rsp_flags}, {2'b10, 16'd3, 5'd0});
        psr_note(1, 8'd0, 5'd0);
        tick();

        // reset in the middle of EXEC abandons the operation
        req0_valid = 1'b1; req0_opcode = 8'd8; req0_a = 16'd5; req0_b = 16'd3;
        @(negedge clk);
        chk("r34_grant", req0_ready, 1'b1);
        tick();
        req0_valid = 1'b0;
        @(negedge clk);
        chk("r34_exec", alu_opcode, 8'd8);
        tick();
        req1_valid = 1'b1; req1_opcode = 8'd0;
        do_reset(2);
        req1_valid = 1'b0;
        for (int i = 0; i < EC + 3; i++) begin
            @(negedge clk);
            chk("r34_no_rsp", rsp_valid, 1'b0);
            tick();
        end
        do_op("r34_after", 0, 8'd0, 16'h7FFF, 16'h0001, {1'b0, 16'h8000, 5'b01000}, 1'b1);

        // randomized traffic against the transaction model
        do_reset(2);
        m_busy = 0; m_last = 1; m_cnt = 0; m_id = 0;
        m_op = 8'd0; m_a = 16'd0; m_b = 16'd0; m_exp = 22'd0;
        pv[0] = 1'b0; pv[1] = 1'b0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            for (int i = 0; i < 2; i++) begin
                if (!pv[i] && $urandom_range(0, 2) == 0) begin
                    int r;
                    r = $urandom_range(0, 27);
                    pv[i]  = 1'b1;
                    pop[i] = (r == 27) ? 8'($urandom_range(23, 255)) : 8'(r);
                    pa[i]  = 16'($urandom);
                    pb[i]  = ($urandom_range(0, 3) == 0) ? pa[i] : 16'($urandom);
                end
            end
            req0_valid = pv[0]; req0_opcode = pop[0]; req0_a = pa[0]; req0_b = pb[0];
            req1_valid = pv[1]; req1_opcode = pop[1]; req1_a = pa[1]; req1_b = pb[1];
            rsp_ready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            psr_check("rnd");
            if (m_busy == 0) begin
                g = -1;
                if (pv[0] && pv[1]) g = 1 - m_last;
                else if (pv[0])     g = 0;
                else if (pv[1])     g = 1;
                chk("rnd_ready", {req0_ready, req1_ready}, {g == 0, g == 1});
                chk("rnd_idle", {rsp_valid, alu_opcode}, {1'b0, 8'd22});
                if (g >= 0) begin
                    m_busy = 1; m_last = g; m_id = g;
                    m_op = pop[g]; m_a = pa[g]; m_b = pb[g];
                    m_cnt = latency(m_op);
                    m_exp = ref_rsp(m_op, m_a, m_b);
                    pv[g] = 1'b0;
                end
            end else begin
                chk("rnd_busy_ready", {req0_ready, req1_ready}, 2'b00);
                if (m_cnt > 0) m_cnt--;
                if (m_cnt > 0) begin
                    chk("rnd_exec", {rsp_valid, alu_opcode, alu_a, alu_b}, {1'b0, m_op, m_a, m_b});
                end else begin
                    chk("rnd_rsp", {rsp_valid, rsp_id, rsp_err, rsp_c, rsp_flags}, {1'b1, m_id[0], m_exp});
                    chk("rnd_resp_alu", alu_opcode, 8'd22);
                    if (rsp_ready) begin
                        m_busy = 0;
                        psr_note(m_id, m_op, m_exp[4:0]);
                    end
                end
            end
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog actual=running expected=finished");
        $fatal(1, "simulation time limit reached");
    end

endmodule
